nic_input_control_unit: RTL and testbench

Receive-side controller of the DES network interface. It accepts packet flits from the NoC router into a packet-granular flit buffer and returns one credit to the router for each buffer slot it frees. When the processing node is free, it assembles one complete packet (header plus DATA_FLITS data flits) and hands it to the node with a start strobe. This is the counterpart to the NIC output control unit, which consumes these credits on the router side.

---
 rtl/nic_input_control_unit.sv | 108 ++++++++++
 tb/tb_nic_input_control_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nic_input_control_unit.sv
// nic_input_control_unit: receive-side NIC controller; buffers router flits, assembles packets for the node, returns credits.
//   clk, reset                          clock and synchronous active-high reset
//   flit_valid_din, flit_din            flit stream from the NoC router
//   node_done_din                       node finished the current packet (honoured only in BUSY)
//   credit_out_dout                     one-cycle credit pulse to the router per delivered packet
//   start_strobe_dout, packet_dout      packet handoff to the node; header in slice 0
//   packets_pending_dout                complete packets held in the buffer
//   overflow_dout                       sticky drop-at-full flag, built only with NIC_INPUT_OVERFLOW_CHECK_EN
module nic_input_control_unit #(
    parameter int FLIT_WIDTH   = 64,
    parameter int DATA_FLITS   = 4,
    parameter int PACKET_SLOTS = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   flit_valid_din,
    input  logic [FLIT_WIDTH-1:0]                  flit_din,
    input  logic                                   node_done_din,
    output logic                                   credit_out_dout,
    output logic                                   start_strobe_dout,
    output logic [(DATA_FLITS+1)*FLIT_WIDTH-1:0]   packet_dout,
    output logic [$clog2(PACKET_SLOTS+1)-1:0]      packets_pending_dout,
    output logic                                   overflow_dout
);
    localparam int D   = PACKET_SLOTS * (DATA_FLITS + 1);
    localparam int AW  = $clog2(D);
    localparam int OW  = $clog2(D + 1);
    localparam int CW  = $clog2(DATA_FLITS + 1);
    localparam int PNW = $clog2(PACKET_SLOTS + 1);
    typedef enum logic [1:0] {IDLE, UNLOAD, STROBE, BUSY} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, unload_cnt_q, unload_cnt_d;
    logic [PNW-1:0] pending_q, pending_d;
    logic [DATA_FLITS:0][FLIT_WIDTH-1:0] packet_q;
    logic [FLIT_WIDTH-1:0] mem [D];
    logic wr_en, rd_en, pkt_done, strobe;
    assign wr_en    = flit_valid_din && (occ_q != OW'(D));
    assign rd_en    = state_q == UNLOAD;
    assign pkt_done = wr_en && (rx_cnt_q == CW'(DATA_FLITS));
    assign strobe   = state_q == STROBE;
    always_comb begin
        wr_ptr_d     = wr_en ? ((wr_ptr_q == AW'(D - 1)) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d     = rd_en ? ((rd_ptr_q == AW'(D - 1)) ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
        occ_d        = occ_q + OW'(wr_en) - OW'(rd_en);
        rx_cnt_d     = wr_en ? (pkt_done ? '0 : rx_cnt_q + CW'(1)) : rx_cnt_q;
        unload_cnt_d = rd_en ? ((unload_cnt_q == CW'(DATA_FLITS)) ? '0 : unload_cnt_q + CW'(1)) : unload_cnt_q;
        // a packet completing during STROBE cancels the decrement
        pending_d    = pending_q + PNW'(pkt_done) - PNW'(strobe);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            rx_cnt_q     <= '0;
            unload_cnt_q <= '0;
            pending_q    <= '0;
            packet_q     <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            rx_cnt_q     <= rx_cnt_d;
            unload_cnt_q <= unload_cnt_d;
            pending_q    <= pending_d;
            if (rd_en) packet_q[unload_cnt_q] <= mem[rd_ptr_q];
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= flit_din;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pending_q != '0) state_d = UNLOAD;
            UNLOAD:  if (unload_cnt_q == CW'(DATA_FLITS)) state_d = STROBE;
            STROBE:  state_d = BUSY;
            BUSY:    if (node_done_din) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        start_strobe_dout = state_q == STROBE;
        credit_out_dout   = state_q == STROBE;
    end
    assign packet_dout          = packet_q;
    assign packets_pending_dout = pending_q;
`ifdef NIC_INPUT_OVERFLOW_CHECK_EN
    logic overflow_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (flit_valid_din && !wr_en) begin
            overflow_q <= 1'b1;
`ifndef SYNTHESIS
            $display("nic_input_control_unit: flit dropped at full buffer, time %0t", $time);
`endif
        end
    end
    assign overflow_dout = overflow_q;
`else
    assign overflow_dout = 1'b0;
`endif
endmodule

// File: tb/tb_nic_input_control_unit.sv
// tb_nic_input_control_unit: scoreboard bench for the NIC input control unit.
module tb_nic_input_control_unit;
    localparam int FW  = 64;
    localparam int DF  = 4;
    localparam int PS  = 4;
    localparam int PKW = (DF + 1) * FW;
`ifdef NIC_INPUT_OVERFLOW_CHECK_EN
    localparam logic EXP_OV = 1'b1;
`else
    localparam logic EXP_OV = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, flit_valid_din = 1'b0, node_done_din = 1'b0;
    logic [FW-1:0] flit_din = '0;
    logic credit_out_dout, start_strobe_dout, overflow_dout;
    logic [PKW-1:0] packet_dout;
    logic [$clog2(PS+1)-1:0] packets_pending_dout;
    int vectors = 0, miscompares = 0, strobes = 0;
    logic [PKW-1:0] exp_q[$];

    nic_input_control_unit #(.FLIT_WIDTH(FW), .DATA_FLITS(DF), .PACKET_SLOTS(PS)) dut (
        .clk(clk), .reset(reset), .flit_valid_din(flit_valid_din), .flit_din(flit_din),
        .node_done_din(node_done_din), .credit_out_dout(credit_out_dout),
        .start_strobe_dout(start_strobe_dout), .packet_dout(packet_dout),
        .packets_pending_dout(packets_pending_dout), .overflow_dout(overflow_dout));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PKW-1:0] act, input logic [PKW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PKW-1:0] pkt(input logic [FW-1:0] base);
        logic [PKW-1:0] p;
        for (int k = 0; k <= DF; k++) p[k*FW +: FW] = base + FW'(k);
        return p;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (start_strobe_dout || credit_out_dout)
                check("credit_with_strobe", PKW'(credit_out_dout), PKW'(start_strobe_dout));
            if (start_strobe_dout) begin
                strobes++;
                if (exp_q.size() == 0) check("unexpected_strobe", PKW'(1), PKW'(0));
                else check("packet", packet_dout, exp_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [FW-1:0] d);
        flit_valid_din = 1'b1;
        flit_din = d;
        tick();
        flit_valid_din = 1'b0;
    endtask

    task automatic send_pkt(input logic [FW-1:0] base);
        for (int k = 0; k <= DF; k++) send_flit(base + FW'(k));
    endtask

    task automatic pulse_done;
        node_done_din = 1'b1;
        tick();
        node_done_din = 1'b0;
    endtask

    task automatic wait_strobe(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (start_strobe_dout) begin
                cyc = i;
                break;
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c, s0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_strobe", PKW'(start_strobe_dout), PKW'(0));
        check("reset_credit", PKW'(credit_out_dout), PKW'(0));
        check("reset_packet", packet_dout, PKW'(0));
        check("reset_pending", PKW'(packets_pending_dout), PKW'(0));
        check("reset_overflow", PKW'(overflow_dout), PKW'(0));
        reset = 1'b0;
        tick();
        // single packet, latency from the last flit
        exp_q.push_back(pkt(64'h10));
        send_pkt(64'h10);
        @(negedge clk);
        check("pending_after_last_flit", PKW'(packets_pending_dout), PKW'(1));
        wait_strobe(c);
        check("strobe_latency_after_pending", PKW'(c), PKW'(6));
        @(negedge clk);
        check("pending_after_strobe", PKW'(packets_pending_dout), PKW'(0));
        check("packet_held", packet_dout, pkt(64'h10));
        pulse_done();
        // five packets streamed with node busy, then a flit at full
        s0 = strobes;
        for (int p = 1; p <= 5; p++) exp_q.push_back(pkt(64'h100 * p));
        for (int p = 1; p <= 5; p++) send_pkt(64'h100 * p);
        @(negedge clk);
        check("pending_full", PKW'(packets_pending_dout), PKW'(4));
        check("one_strobe_while_busy", PKW'(strobes - s0), PKW'(1));
        check("overflow_before_drop", PKW'(overflow_dout), PKW'(0));
        send_flit(64'hDEAD);
        @(negedge clk);
        check("overflow_after_drop", PKW'(overflow_dout), PKW'(EXP_OV));
        check("pending_after_drop", PKW'(packets_pending_dout), PKW'(4));
        repeat (10) tick();
        check("no_strobe_without_done", PKW'(strobes - s0), PKW'(1));
        for (int p = 2; p <= 5; p++) begin
            pulse_done();
            wait_strobe(c);
            check("drain_strobe_seen", PKW'(c != 0), PKW'(1));
        end
        pulse_done();
        @(negedge clk);
        check("pending_drained", PKW'(packets_pending_dout), PKW'(0));
        // packet completes in the same cycle as the previous STROBE
        exp_q.push_back(pkt(64'hA00));
        exp_q.push_back(pkt(64'hB00));
        tick();
        send_pkt(64'hA00);
        tick();
        tick();
        for (int k = 0; k < DF; k++) send_flit(64'hB00 + FW'(k));
        flit_valid_din = 1'b1;
        flit_din = 64'hB00 + FW'(DF);
        @(negedge clk);
        check("strobe_coincident", PKW'(start_strobe_dout), PKW'(1));
        check("pending_coincident", PKW'(packets_pending_dout), PKW'(1));
        tick();
        flit_valid_din = 1'b0;
        @(negedge clk);
        check("pending_unchanged", PKW'(packets_pending_dout), PKW'(1));
        pulse_done();
        wait_strobe(c);
        check("second_packet_strobe", PKW'(c != 0), PKW'(1));
        pulse_done();
        // node_done in IDLE and UNLOAD is ignored
        exp_q.push_back(pkt(64'hC00));
        send_pkt(64'hC00);
        pulse_done();
        tick();
        pulse_done();
        wait_strobe(c);
        check("latency_with_stray_done", PKW'(c), PKW'(4));
        repeat (8) tick();
        exp_q.push_back(pkt(64'hD00));
        send_pkt(64'hD00);
        repeat (10) tick();
        check("busy_holds_after_stray_done", PKW'(exp_q.size()), PKW'(1));
        pulse_done();
        wait_strobe(c);
        check("post_busy_strobe", PKW'(c != 0), PKW'(1));
        pulse_done();
        // reset in the middle of UNLOAD
        send_pkt(64'hE00);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midreset_strobe", PKW'(start_strobe_dout), PKW'(0));
        check("midreset_credit", PKW'(credit_out_dout), PKW'(0));
        check("midreset_packet", packet_dout, PKW'(0));
        check("midreset_pending", PKW'(packets_pending_dout), PKW'(0));
        check("midreset_overflow", PKW'(overflow_dout), PKW'(0));
        reset = 1'b0;
        s0 = strobes;
        repeat (15) tick();
        check("no_strobe_after_reset", PKW'(strobes - s0), PKW'(0));
        exp_q.push_back(pkt(64'hF00));
        send_pkt(64'hF00);
        wait_strobe(c);
        check("post_reset_latency", PKW'(c), PKW'(7));
        pulse_done();
        repeat (3) tick();
        check("scoreboard_empty", PKW'(exp_q.size()), PKW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
